// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM access arbiter.
package rom_arb_pkg;
  localparam int NUM_REQ     = 2;
  localparam int PORT_IFETCH = 0;
  localparam int PORT_LOAD   = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  function automatic logic [NUM_REQ-1:0] port_onehot(input logic idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester handshake and ROM-side bus of the arbiter; slave = arbiter view.
interface rom_access_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  import rom_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_error;
  logic                          rom_en;
  logic [ADDR_WIDTH-1:0]         rom_address;
  logic [DATA_WIDTH-1:0]         rom_data;
  logic                          rom_error;

  modport slave (
    input  req_valid, req_addr, rsp_ready, rom_data, rom_error,
    output req_ready, rsp_valid, rsp_data, rsp_error, rom_en, rom_address
  );

  modport master (
    output req_valid, req_addr, rsp_ready, rom_data, rom_error,
    input  req_ready, rsp_valid, rsp_data, rsp_error, rom_en, rom_address
  );
endinterface

// File: rtl/rom_rr_pick.sv
// Two-way round-robin pick: the priority port wins if valid, otherwise the other one.
module rom_rr_pick
  import rom_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               rr_prio,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_idx
);
  always_comb begin
    grant_idx = req_valid[rr_prio] ? rr_prio : ~rr_prio;
    grant     = (|req_valid) ? port_onehot(grant_idx) : '0;
  end
endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one ROM between instruction fetch and data load: round-robin grant,
// one access in flight, fixed-latency wait, response held until accepted.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int ROM_DEPTH   = 256,
  parameter int ROM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rom_access_arbiter_if.slave  bus,
  output logic                 busy
);
  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ROM_LATENCY - 1);
  // A full-depth ROM has no invalid addresses, so the compare folds away.
  localparam bit RANGE_CHK = ROM_DEPTH < (2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(ROM_DEPTH);

  state_t                state, state_d;
  logic                  rr_prio, rr_d;
  logic                  gidx, gidx_d;
  logic                  rom_en_q, rom_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [NUM_REQ-1:0]    pick_grant, req_ready, rsp_valid;
  logic                  pick_idx, oor;
  logic [ADDR_WIDTH-1:0] sel_addr;

  rom_rr_pick u_pick (
    .req_valid (bus.req_valid),
    .rr_prio   (rr_prio),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign sel_addr = pick_idx ? bus.req_addr[NUM_REQ*ADDR_WIDTH-1:ADDR_WIDTH]
                             : bus.req_addr[ADDR_WIDTH-1:0];
  assign oor = RANGE_CHK && ({1'b0, sel_addr} >= DEPTH_LIM);

  always_comb begin
    state_d   = state;
    rr_d      = rr_prio;
    gidx_d    = gidx;
    rom_en_d  = rom_en_q;
    addr_d    = addr_q;
    cnt_d     = cnt;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state)
      ST_IDLE: if (|bus.req_valid) begin
        req_ready = pick_grant;
        gidx_d    = pick_idx;
        if (oor) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          addr_d   = sel_addr;
          rom_en_d = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: if (cnt == '0) begin
        data_d   = bus.rom_data;
        err_d    = bus.rom_error;
        rom_en_d = 1'b0;
        state_d  = ST_RESP;
      end else begin
        cnt_d = cnt - 1'b1;
      end
      ST_RESP: begin
        rsp_valid = port_onehot(gidx);
        if (bus.rsp_ready[gidx]) begin
          rr_d    = ~gidx;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_prio  <= 1'(PORT_IFETCH);
      gidx     <= 1'b0;
      rom_en_q <= 1'b0;
      addr_q   <= '0;
      cnt      <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      rr_prio  <= rr_d;
      gidx     <= gidx_d;
      rom_en_q <= rom_en_d;
      addr_q   <= addr_d;
      cnt      <= cnt_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_data    = data_q;
  assign bus.rsp_error   = err_q;
  assign bus.rom_en      = rom_en_q;
  assign bus.rom_address = addr_q;
  assign busy            = (state != ST_IDLE);
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench: four arbiter instances (latency 1..4, instance 0 with a 200-word ROM).
module tb_rom_access_arbiter;
  import rom_arb_pkg::*;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int en_hits0 = 0;

  logic [1:0]  req_valid [N];
  logic [15:0] req_addr  [N];
  logic [1:0]  rsp_ready [N];
  logic        rom_err_f [N];
  logic [1:0]  req_ready [N];
  logic [1:0]  rsp_valid [N];
  logic [15:0] rsp_data  [N];
  logic        rsp_error [N];
  logic        rom_en    [N];
  logic [7:0]  rom_addr  [N];
  logic        busy      [N];

  for (genvar k = 0; k < N; k++) begin : g
    localparam int LAT   = k + 1;
    localparam int DEPTH = (k == 0) ? 200 : 256;
    rom_access_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();
    int en_cnt = 0;
    // ROM model: word valid only after rom_en has been up LAT-1 cycles.
    always @(posedge clk) en_cnt <= (bus.rom_en === 1'b1) ? en_cnt + 1 : 0;
    assign bus.rom_data  = (bus.rom_en === 1'b1 && en_cnt >= LAT - 1)
                           ? 16'hA000 + {8'h00, bus.rom_address} : 16'hDEAD;
    assign bus.rom_error = rom_err_f[k];
    assign bus.req_valid = req_valid[k];
    assign bus.req_addr  = req_addr[k];
    assign bus.rsp_ready = rsp_ready[k];
    assign req_ready[k]  = bus.req_ready;
    assign rsp_valid[k]  = bus.rsp_valid;
    assign rsp_data[k]   = bus.rsp_data;
    assign rsp_error[k]  = bus.rsp_error;
    assign rom_en[k]     = bus.rom_en;
    assign rom_addr[k]   = bus.rom_address;
    rom_access_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ROM_DEPTH(DEPTH), .ROM_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy[k])
    );
  end

  always @(negedge clk) if (rom_en[0] === 1'b1) en_hits0++;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = '0; req_addr[k] = '0; rsp_ready[k] = '0; rom_err_f[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic transact(input int k, input int p, input logic [7:0] a,
                          output int lat, output logic [15:0] d, output logic e, output bit ok);
    int n;
    ok = 1'b1; lat = 0; d = '0; e = 1'b0;
    @(negedge clk);
    req_valid[k][p] = 1'b1;
    if (p == PORT_LOAD) req_addr[k][15:8] = a; else req_addr[k][7:0] = a;
    #1;
    n = 0;
    while (req_ready[k][p] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    if (req_ready[k][p] !== 1'b1) begin ok = 1'b0; req_valid[k][p] = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid[k][p] = 1'b0;
    lat = 1;
    while (rsp_valid[k][p] !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    if (rsp_valid[k][p] !== 1'b1) ok = 1'b0;
    d = rsp_data[k]; e = rsp_error[k];
    rsp_ready[k][p] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k][p] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < N; k += 3) begin
      checks++; if (busy[k] !== 1'b0) begin failures++; $display("FAIL rst_busy[%0d] got=%b exp=0", k, busy[k]); end
      checks++; if (rom_en[k] !== 1'b0) begin failures++; $display("FAIL rst_rom_en[%0d] got=%b exp=0", k, rom_en[k]); end
      checks++; if (rom_addr[k] !== 8'h00) begin failures++; $display("FAIL rst_rom_addr[%0d] got=%h exp=00", k, rom_addr[k]); end
      checks++; if (rsp_valid[k] !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid[%0d] got=%b exp=00", k, rsp_valid[k]); end
      checks++; if (rsp_data[k] !== 16'h0000) begin failures++; $display("FAIL rst_rsp_data[%0d] got=%h exp=0000", k, rsp_data[k]); end
      checks++; if (rsp_error[k] !== 1'b0) begin failures++; $display("FAIL rst_rsp_error[%0d] got=%b exp=0", k, rsp_error[k]); end
      checks++; if (req_ready[k] !== 2'b00) begin failures++; $display("FAIL rst_req_ready[%0d] got=%b exp=00", k, req_ready[k]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req_valid[0] = 2'b01; req_addr[0] = 16'h0010;
    #1;
    checks++; if (req_ready[0] !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready[0]); end
    @(negedge clk); #1;
    checks++; if (req_ready[0] !== 2'b00) begin failures++; $display("FAIL single_ready_drop got=%b exp=00", req_ready[0]); end
    checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy[0]); end
    checks++; if (rom_en[0] !== 1'b1 || rom_addr[0] !== 8'h10) begin failures++; $display("FAIL single_rom got=%b/%h exp=1/10", rom_en[0], rom_addr[0]); end
    checks++; if (rsp_valid[0] !== 2'b00) begin failures++; $display("FAIL single_early_rsp got=%b exp=00", rsp_valid[0]); end
    req_valid[0] = 2'b00;
    @(negedge clk); #1;
    checks++; if (rsp_valid[0] !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid[0]); end
    checks++; if (rsp_data[0] !== 16'hA010) begin failures++; $display("FAIL single_data got=%h exp=A010", rsp_data[0]); end
    checks++; if (rsp_error[0] !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", rsp_error[0]); end
    checks++; if (rom_en[0] !== 1'b0) begin failures++; $display("FAIL single_rom_en_off got=%b exp=0", rom_en[0]); end
    rsp_ready[0] = 2'b01;
    @(negedge clk); #1;
    checks++; if (rsp_valid[0] !== 2'b00 || busy[0] !== 1'b0) begin failures++; $display("FAIL single_done got=%b/%b exp=00/0", rsp_valid[0], busy[0]); end
    rsp_ready[0] = 2'b00;
  endtask

  task automatic test_contention();
    logic [1:0]  gr [4];
    logic [1:0]  rp [4];
    logic [15:0] rd [4];
    int ng = 0, nr = 0;
    bit both = 1'b0;
    do_reset();
    @(negedge clk);
    req_addr[0] = 16'h0201; req_valid[0] = 2'b11; rsp_ready[0] = 2'b11;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      #1;
      if (req_ready[0] === 2'b11) both = 1'b1;
      if (req_ready[0] !== 2'b00 && ng < 4) begin gr[ng] = req_ready[0]; ng++; end
      if (rsp_valid[0] !== 2'b00) begin rp[nr] = rsp_valid[0]; rd[nr] = rsp_data[0]; nr++; end
      @(negedge clk);
    end
    req_valid[0] = 2'b00; rsp_ready[0] = 2'b00;
    checks++; if (nr != 4 || ng != 4) begin failures++; $display("FAIL cont_count got=%0d/%0d exp=4/4", ng, nr); end
    checks++; if (both) begin failures++; $display("FAIL cont_ready_both got=1 exp=0"); end
    for (int i = 0; i < nr && i < ng; i++) begin
      logic [1:0]  eg;
      logic [15:0] ed;
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      ed = (i % 2 == 1) ? 16'hA002 : 16'hA001;
      checks++; if (gr[i] !== eg) begin failures++; $display("FAIL cont_grant[%0d] got=%b exp=%b", i, gr[i], eg); end
      checks++; if (rp[i] !== eg) begin failures++; $display("FAIL cont_rsp_port[%0d] got=%b exp=%b", i, rp[i], eg); end
      checks++; if (rd[i] !== ed) begin failures++; $display("FAIL cont_data[%0d] got=%h exp=%h", i, rd[i], ed); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    @(negedge clk);
    req_valid[0] = 2'b10; req_addr[0] = 16'h2011;
    #1;
    checks++; if (req_ready[0] !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", req_ready[0]); end
    @(negedge clk);
    // port 0 now waiting, and its rsp_ready must not complete port 1's response
    req_valid[0] = 2'b11; rsp_ready[0] = 2'b01;
    #1;
    while (rsp_valid[0] === 2'b00 && n < 10) begin @(negedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid[0] !== 2'b10) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=10", c, rsp_valid[0]); end
      checks++; if (rsp_data[0] !== 16'hA020) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=A020", c, rsp_data[0]); end
      checks++; if (req_ready[0] !== 2'b00) begin failures++; $display("FAIL bp_no_grant[%0d] got=%b exp=00", c, req_ready[0]); end
      @(negedge clk); #1;
    end
    rsp_ready[0] = 2'b11;
    @(negedge clk); #1;
    checks++; if (busy[0] !== 1'b0 || rsp_valid[0] !== 2'b00) begin failures++; $display("FAIL bp_idle got=%b/%b exp=0/00", busy[0], rsp_valid[0]); end
    checks++; if (req_ready[0] !== 2'b01) begin failures++; $display("FAIL bp_rr_next got=%b exp=01", req_ready[0]); end
    req_valid[0] = 2'b00; rsp_ready[0] = 2'b00;
  endtask

  task automatic test_error();
    int lat, h;
    logic [15:0] d;
    logic e;
    bit ok;
    do_reset();
    h = en_hits0;
    transact(0, PORT_LOAD, 8'hC8, lat, d, e, ok);
    checks++; if (!ok || lat != 1) begin failures++; $display("FAIL oor_latency got=%0d ok=%0d exp=1", lat, ok); end
    checks++; if (d !== 16'h0000 || e !== 1'b1) begin failures++; $display("FAIL oor_rsp got=%h/%b exp=0000/1", d, e); end
    checks++; if (en_hits0 != h) begin failures++; $display("FAIL oor_rom_en got=%0d exp=0", en_hits0 - h); end
    transact(0, PORT_IFETCH, 8'hC7, lat, d, e, ok);
    checks++; if (!ok || d !== 16'hA0C7 || e !== 1'b0) begin failures++; $display("FAIL last_word got=%h/%b exp=A0C7/0", d, e); end
    transact(1, PORT_LOAD, 8'hFF, lat, d, e, ok);
    checks++; if (!ok || d !== 16'hA0FF || e !== 1'b0) begin failures++; $display("FAIL full_depth got=%h/%b exp=A0FF/0", d, e); end
    rom_err_f[0] = 1'b1;
    transact(0, PORT_LOAD, 8'h05, lat, d, e, ok);
    rom_err_f[0] = 1'b0;
    checks++; if (!ok || d !== 16'hA005 || e !== 1'b1) begin failures++; $display("FAIL rom_err got=%h/%b exp=A005/1", d, e); end
  endtask

  task automatic test_reset_midop();
    int seen = 0, lat;
    logic [15:0] d;
    logic e;
    bit ok;
    do_reset();
    @(negedge clk);
    req_valid[2] = 2'b01; req_addr[2] = 16'h0007;
    #1;
    checks++; if (req_ready[2] !== 2'b01) begin failures++; $display("FAIL mid_grant got=%b exp=01", req_ready[2]); end
    @(negedge clk);
    req_valid[2] = 2'b00;
    #1;
    checks++; if (busy[2] !== 1'b1 || rom_en[2] !== 1'b1) begin failures++; $display("FAIL mid_wait got=%b/%b exp=1/1", busy[2], rom_en[2]); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy[2] !== 1'b0 || rom_en[2] !== 1'b0) begin failures++; $display("FAIL mid_rst_ctl got=%b/%b exp=0/0", busy[2], rom_en[2]); end
    checks++; if (rom_addr[2] !== 8'h00) begin failures++; $display("FAIL mid_rst_addr got=%h exp=00", rom_addr[2]); end
    checks++; if (rsp_valid[2] !== 2'b00 || rsp_data[2] !== 16'h0 || rsp_error[2] !== 1'b0) begin
      failures++; $display("FAIL mid_rst_rsp got=%b/%h/%b exp=00/0000/0", rsp_valid[2], rsp_data[2], rsp_error[2]); end
    @(negedge clk);
    rst_n = 1'b1; rsp_ready[2] = 2'b11;
    repeat (8) begin @(negedge clk); if (rsp_valid[2] !== 2'b00) seen++; end
    rsp_ready[2] = 2'b00;
    checks++; if (seen != 0 || busy[2] !== 1'b0) begin failures++; $display("FAIL mid_no_rsp got=%0d/%b exp=0/0", seen, busy[2]); end
    transact(2, PORT_LOAD, 8'h33, lat, d, e, ok);
    checks++; if (!ok || lat != 4 || d !== 16'hA033 || e !== 1'b0) begin
      failures++; $display("FAIL mid_after got=%0d/%h/%b exp=4/A033/0", lat, d, e); end
  endtask

  task automatic test_latency();
    int lat;
    logic [15:0] d;
    logic e;
    bit ok;
    do_reset();
    for (int k = 0; k < N; k++) begin
      transact(k, k % 2, 8'h40 + 8'(k), lat, d, e, ok);
      checks++; if (!ok || lat != k + 2) begin failures++; $display("FAIL lat_L%0d got=%0d exp=%0d", k + 1, lat, k + 2); end
      checks++; if (d !== 16'hA040 + 16'(k) || e !== 1'b0) begin failures++; $display("FAIL lat_data_L%0d got=%h/%b exp=%h/0", k + 1, d, e, 16'hA040 + 16'(k)); end
    end
  endtask

  task automatic test_back_to_back();
    int gc [3];
    int ng = 0;
    bit p1 = 1'b0;
    do_reset();
    @(negedge clk);
    req_valid[1] = 2'b01; req_addr[1] = 16'h0022; rsp_ready[1] = 2'b01;
    for (int c = 0; c < 30 && ng < 3; c++) begin
      #1;
      if (req_ready[1][1] === 1'b1) p1 = 1'b1;
      if (req_ready[1] === 2'b01) begin gc[ng] = c; ng++; end
      @(negedge clk);
    end
    req_valid[1] = 2'b00; rsp_ready[1] = 2'b00;
    @(negedge clk);
    checks++; if (ng != 3 || p1) begin failures++; $display("FAIL b2b_grants got=%0d/%0d exp=3/0", ng, p1); end
    for (int i = 1; i < ng; i++) begin
      checks++; if (gc[i] - gc[i-1] != 4) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=4", i, gc[i] - gc[i-1]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_error();
    test_reset_midop();
    test_latency();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
